ub_dequant_reader: RTL and testbench

Reads a contiguous run of int8 entries from the unified buffer and dequantizes each into a signed 32-bit value. Dequantization is the exact inverse of the post-accumulator affine quantizer: out = round((q − zero_point) × scale), with scale in Q8.8. Results are streamed on a valid/ready interface toward the loss, host-readback and re-accumulation paths. Reads are issued on a credit basis, so output backpressure never drops data.

---
 rtl/ub_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 39 +++
 rtl/ub_dequant_reader.sv | 92 +++++++++
 tb/tb_ub_dequant_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
// ub_pkg: shared FSM states, Q8.8 constants and the int8 dequantize function
package ub_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam int FRAC_BITS = 8;
  localparam int ROUND_HALF = 128;
  function automatic logic signed [31:0] dequant(
    input logic [7:0] q,
    input logic unsigned_mode,
    input logic passthrough,
    input logic signed [7:0] zp,
    input logic signed [15:0] scale
  );
    logic signed [9:0] q_ext, diff;
    logic signed [25:0] d26, s26, prod, rnd, sh;
    q_ext = unsigned_mode ? {2'b00, q} : {{2{q[7]}}, q};
    diff = q_ext - {{2{zp[7]}}, zp};
    d26 = {{16{diff[9]}}, diff};
    s26 = {{10{scale[15]}}, scale};
    prod = d26 * s26;
    rnd = prod + 26'(ROUND_HALF);
    sh = rnd >>> FRAC_BITS;
    return passthrough ? {{22{q_ext[9]}}, q_ext} : {{6{sh[25]}}, sh};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with full/empty/count; simultaneous write and pop allowed when full
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign full = cnt == DEPTH[AW:0];
  assign empty = cnt == '0;
  assign rd_data = mem[rp];
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/ub_dequant_reader.sv
// ub_dequant_reader: credit-based UB int8 reader that dequantizes entries into a valid/ready stream
module ub_dequant_reader
  import ub_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0] count,
  input  logic passthrough,
  input  logic unsigned_mode,
  input  logic signed [15:0] deq_scale,
  input  logic signed [7:0] zero_point,
  output logic busy,
  output logic done,
  output logic ub_rd_en,
  output logic [ADDR_W-1:0] ub_rd_addr,
  input  logic [7:0] ub_rd_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0] cnt_q, issue_idx, acc_cnt;
  logic pass_q, uns_q, inflight, full, empty, pop;
  logic signed [15:0] scale_q;
  logic signed [7:0] zp_q;
  logic [CW-1:0] occ;
  logic [CW:0] used;
  logic [31:0] head;
  assign used = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign ub_rd_en = state == READ && used < FIFO_DEPTH[CW:0];
  assign ub_rd_addr = base_q + issue_idx[ADDR_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign out_valid = !empty;
  assign out_data = empty ? '0 : head;
  assign pop = !empty && out_ready;
  always_comb begin
    state_nx = state == IDLE  ? (start ? (count == '0 ? DONE : READ) : IDLE) :
               state == READ  ? (ub_rd_en && issue_idx == cnt_q - 1'b1 ? DRAIN : READ) :
               state == DRAIN ? (acc_cnt + {{ADDR_W{1'b0}}, pop} == cnt_q ? DONE : DRAIN) :
                                IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inflight <= 1'b0;
      base_q <= '0;
      cnt_q <= '0;
      issue_idx <= '0;
      acc_cnt <= '0;
      pass_q <= 1'b0;
      uns_q <= 1'b0;
      scale_q <= '0;
      zp_q <= '0;
    end else begin
      state <= state_nx;
      inflight <= ub_rd_en;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        cnt_q <= count;
        pass_q <= passthrough;
        uns_q <= unsigned_mode;
        scale_q <= deq_scale;
        zp_q <= zero_point;
        issue_idx <= '0;
        acc_cnt <= '0;
      end else begin
        if (ub_rd_en) issue_idx <= issue_idx + 1'b1;
        if (pop) acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end
  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(inflight),
    .wr_data(dequant(ub_rd_data, uns_q, pass_q, zp_q, scale_q)),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .cnt(occ)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inflight && full && !pop));
endmodule

// File: tb/tb_ub_dequant_reader.sv
// tb_ub_dequant_reader: directed bench with an arithmetic reference model and per-cycle output checking
module tb_ub_dequant_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [10:0] count = '0;
  logic passthrough = 1'b0;
  logic unsigned_mode = 1'b0;
  logic signed [15:0] deq_scale = '0;
  logic signed [7:0] zero_point = '0;
  logic busy, done, ub_rd_en, out_valid;
  logic [9:0] ub_rd_addr;
  logic [7:0] ub_rd_data = '0;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0] mem [1024];
  int cyc = 0, t0 = 0, bp_lo = 1, bp_hi = 0;
  int errors = 0, checks = 0;
  int exp_q[$], got_v[$], got_c[$], rd_log[$], rd_rel[$];
  int dr;

  ub_dequant_reader #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .passthrough(passthrough), .unsigned_mode(unsigned_mode), .deq_scale(deq_scale),
    .zero_point(zero_point), .busy(busy), .done(done), .ub_rd_en(ub_rd_en),
    .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ub_rd_data <= mem[ub_rd_addr];
  always @(posedge clk) begin
    #1;
    out_ready = !((cyc - t0) >= bp_lo && (cyc - t0) <= bp_hi);
  end

  function automatic int model(input logic [7:0] q, input bit uns, input bit pass, input int zp, input int s);
    int qe;
    qe = uns ? int'({24'd0, q}) : int'($signed(q));
    if (pass) return qe;
    return int'($floor(real'((qe - zp) * s) / 256.0 + 0.5));
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ub_rd_en) begin
      rd_log.push_back(int'(ub_rd_addr));
      rd_rel.push_back(cyc - t0);
    end
    if (!rst && out_valid && out_ready) begin
      got_v.push_back($signed(out_data));
      got_c.push_back(cyc - t0);
      if (exp_q.size() == 0) chk("unexpected_output", $signed(out_data), 0);
      else chk("stream_data", $signed(out_data), exp_q.pop_front());
    end
  end

  task automatic run(input int base, input int n, input bit pass, input bit uns, input int s, input int zp, output int done_rel);
    for (int i = 0; i < n; i++) exp_q.push_back(model(mem[(base + i) % 1024], uns, pass, zp, s));
    rd_log.delete(); rd_rel.delete(); got_v.delete(); got_c.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base[9:0]; count = n[10:0]; passthrough = pass;
    unsigned_mode = uns; deq_scale = s[15:0]; zero_point = zp[7:0]; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    done_rel = -1;
    for (int k = 0; k < 300 && done_rel < 0; k++) begin
      @(negedge clk);
      if (done) done_rel = cyc - t0;
    end
    if (done_rel < 0) chk("done_timeout", done_rel, 0);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("all_delivered", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hFB; mem[6] = 8'h00; mem[7] = 8'h7F; mem[8] = 8'h80;
    mem[20] = 8'd20; mem[21] = 8'd21; mem[22] = 8'hFF; mem[30] = 8'hFF;
    chk("model_round_up", model(8'd21, 0, 0, 10, 384), 17);
    chk("model_round_neg", model(8'hFF, 0, 0, 10, 384), -16);
    chk("model_unsigned", model(8'hFF, 1, 0, -1, 256), 256);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(ub_rd_en), 0);
    chk("rst_rd_addr", int'(ub_rd_addr), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);

    run(5, 4, 0, 0, 256, 0, dr);
    chk("basic_done_cycle", dr, 7);
    chk("basic_n", got_v.size(), 4);
    if (got_v.size() == 4) begin
      chk("basic_v0", got_v[0], -5);
      chk("basic_v1", got_v[1], 0);
      chk("basic_v2", got_v[2], 127);
      chk("basic_v3", got_v[3], -128);
      chk("basic_c0", got_c[0], 3);
      chk("basic_c3", got_c[3], 6);
    end
    chk("basic_first_read_cycle", rd_rel.size() > 0 ? rd_rel[0] : -1, 1);
    chk("basic_first_read_addr", rd_log.size() > 0 ? rd_log[0] : -1, 5);

    run(20, 3, 0, 0, 384, 10, dr);
    if (got_v.size() == 3) begin
      chk("round_q20", got_v[0], 15);
      chk("round_q21", got_v[1], 17);
      chk("round_qm1", got_v[2], -16);
    end else chk("round_n", got_v.size(), 3);

    run(30, 1, 0, 1, 256, -1, dr);
    chk("uns_ff", got_v.size() == 1 ? got_v[0] : -999, 256);
    run(30, 1, 1, 1, 768, 5, dr);
    chk("pass_uns_ff", got_v.size() == 1 ? got_v[0] : -999, 255);
    run(30, 1, 1, 0, 768, 5, dr);
    chk("pass_sgn_ff", got_v.size() == 1 ? got_v[0] : -999, -1);

    bp_lo = 2; bp_hi = 12;
    run(40, 10, 0, 0, 300, -7, dr);
    begin
      int early = 0;
      foreach (rd_rel[i]) if (rd_rel[i] <= 12) early++;
      chk("bp_reads_while_stalled", early, 4);
    end
    chk("bp_total_reads", rd_log.size(), 10);
    chk("bp_delivered", got_v.size(), 10);
    bp_lo = 1; bp_hi = 0;

    run(1022, 4, 0, 1, 256, 0, dr);
    chk("wrap_n", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_a0", rd_log[0], 1022);
      chk("wrap_a1", rd_log[1], 1023);
      chk("wrap_a2", rd_log[2], 0);
      chk("wrap_a3", rd_log[3], 1);
    end

    run(0, 0, 0, 0, 256, 0, dr);
    chk("zero_done_cycle", dr, 1);
    chk("zero_reads", rd_log.size(), 0);

    fork
      run(5, 4, 0, 0, 256, 0, dr);
      begin
        repeat (3) @(posedge clk);
        #2 start = 1'b1; base_addr = 10'd100; count = 11'd1;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    chk("busy_start_done_cycle", dr, 7);
    chk("busy_start_reads", rd_log.size(), 4);
    chk("busy_start_addr", rd_log.size() > 3 ? rd_log[3] : -1, 8);

    for (int i = 0; i < 8; i++) exp_q.push_back(model(mem[200 + i], 0, 0, 0, 256));
    rd_log.delete(); rd_rel.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd200; count = 11'd8; passthrough = 1'b0;
    unsigned_mode = 1'b0; deq_scale = 16'sd256; zero_point = 8'sd0; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_reads", rd_log.size(), 3);
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_rd_en", int'(ub_rd_en), 0);
    chk("mid_rst_rd_addr", int'(ub_rd_addr), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_rd_en", int'(ub_rd_en), 0);
    end

    run(300, 5, 0, 0, -200, 3, dr);
    chk("after_rst_done_cycle", dr, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
